// File: rtl/edge_row_cache_pkg.sv
// rtl/edge_row_cache_pkg.sv - shared types, defaults and address helper for the edge row cache
// Purpose: default widths, the cache and fill FSM state enums, and elem_addr(), which
//          maps a matrix element (row, col) of an n x n matrix to its byte address.
// Ports:   none (package)
package edge_cache_pkg;

  localparam int DEFAULT_MAX_NODES   = 16;
  localparam int DEFAULT_INDEX_WIDTH = 8;
  localparam int DEFAULT_VALUE_WIDTH = 16;
  localparam int DEFAULT_MADDR_WIDTH = 16;
  localparam int DEFAULT_MDATA_WIDTH = 32;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_REQ, FILL_WAIT, RESPOND} state_t;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT} fill_state_t;

  // 32-bit result; callers truncate to their address width.
  function automatic logic [31:0] elem_addr(input logic [31:0] base, input logic [31:0] row,
                                            input logic [31:0] col, input logic [31:0] n,
                                            input logic [31:0] word_bytes);
    return base + (row * n + col) * word_bytes;
  endfunction

endpackage

// File: rtl/edge_row_cache_if.sv
// rtl/edge_row_cache_if.sv - query handshake between relaxation logic and the edge row cache
// Purpose: groups the query request and its registered response.
// Ports:   query_enable/from_node/to_node (requester -> cache),
//          ready/edge_value/out_of_range (cache -> requester).
interface edge_row_cache_if #(
  parameter int INDEX_WIDTH = 8,
  parameter int VALUE_WIDTH = 16
);
  logic                   query_enable;
  logic [INDEX_WIDTH-1:0] from_node;
  logic [INDEX_WIDTH-1:0] to_node;
  logic                   ready;
  logic [VALUE_WIDTH-1:0] edge_value;
  logic                   out_of_range;

  modport master (output query_enable, from_node, to_node,
                  input  ready, edge_value, out_of_range);
  modport slave  (input  query_enable, from_node, to_node,
                  output ready, edge_value, out_of_range);
endinterface

// File: rtl/edge_row_cache_fill.sv
// rtl/edge_row_cache_fill.sv - row fill engine: column counter, address generation, read handshake
// Purpose: on start, samples base/row/n and reads n words of one row, one request per word.
//          abort lets the outstanding word complete, then ends the fill without complete.
// Ports:   start/abort in; busy, req, addr out (owner tri-states the bus);
//          wr_en/wr_col/wr_data per accepted word; done on the last handshake,
//          complete with done when the whole row was read.
module edge_row_fill
  import edge_cache_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
  parameter int WORD_BYTES  = MDATA_WIDTH / 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [MADDR_WIDTH-1:0] base_address,
  input  logic [INDEX_WIDTH-1:0] row,
  input  logic [INDEX_WIDTH-1:0] n,
  input  logic                   mem_read_ready,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  output logic                   busy,
  output logic                   req,
  output logic [MADDR_WIDTH-1:0] addr,
  output logic                   wr_en,
  output logic [INDEX_WIDTH-1:0] wr_col,
  output logic [VALUE_WIDTH-1:0] wr_data,
  output logic                   done,
  output logic                   complete
);
  fill_state_t            phase_q, phase_d;
  logic [INDEX_WIDTH-1:0] col_q, col_d, row_q, row_d, n_q, n_d;
  logic [MADDR_WIDTH-1:0] base_q, base_d;
  logic                   abort_q, abort_d;
  logic                   stop;
  logic                   unused_data;

  always_comb begin
    phase_d  = phase_q;
    col_d    = col_q;
    row_d    = row_q;
    n_d      = n_q;
    base_d   = base_q;
    abort_d  = abort_q;
    wr_en    = 1'b0;
    done     = 1'b0;
    complete = 1'b0;
    stop     = abort | abort_q;
    case (phase_q)
      F_IDLE: begin
        if (start) begin
          phase_d = F_REQ;
          col_d   = '0;
          row_d   = row;
          n_d     = n;
          base_d  = base_address;
          abort_d = 1'b0;
        end
      end
      F_REQ: begin
        phase_d = F_WAIT;
        abort_d = stop;
      end
      F_WAIT: begin
        abort_d = stop;
        if (mem_read_ready) begin
          wr_en = 1'b1;
          if (stop || col_q == n_q - INDEX_WIDTH'(1)) begin
            done     = 1'b1;
            complete = !stop;
            phase_d  = F_IDLE;
          end else begin
            col_d   = col_q + INDEX_WIDTH'(1);
            phase_d = F_REQ;
          end
        end
      end
      default: phase_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q <= F_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      n_q     <= '0;
      base_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      col_q   <= col_d;
      row_q   <= row_d;
      n_q     <= n_d;
      base_q  <= base_d;
      abort_q <= abort_d;
    end
  end

  assign busy        = (phase_q != F_IDLE);
  assign req         = (phase_q == F_REQ);
  assign addr        = MADDR_WIDTH'(elem_addr(32'(base_q), 32'(row_q), 32'(col_q), 32'(n_q),
                                              32'(WORD_BYTES)));
  assign wr_col      = col_q;
  assign wr_data     = mem_read_data[VALUE_WIDTH-1:0];
  assign unused_data = ^mem_read_data;
endmodule

// File: rtl/edge_row_cache.sv
// rtl/edge_row_cache.sv - fully associative row cache for adjacency-matrix edge weights
// Purpose: answers (from_node, to_node) queries from NUM_LINES cached rows, filling a whole
//          row from BlockRam on a miss; round-robin replacement once all lines are valid.
// Ports:   clock/reset; base_address/number_of_nodes matrix geometry; invalidate pulse;
//          q query handshake (slave); mem_* BlockRam read port, tri-stated when idle;
//          hit_count/miss_count saturating statistics.
module edge_row_cache
  import edge_cache_pkg::*;
#(
  parameter int MAX_NODES   = DEFAULT_MAX_NODES,
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  parameter int MADDR_WIDTH = DEFAULT_MADDR_WIDTH,
  parameter int MDATA_WIDTH = DEFAULT_MDATA_WIDTH,
  parameter int NUM_LINES   = 4,
  parameter int WORD_BYTES  = MDATA_WIDTH / 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [MADDR_WIDTH-1:0] base_address,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic                   invalidate,
  edge_row_cache_if.slave        q,
  output wire  [MADDR_WIDTH-1:0] mem_addr,
  input  logic [MDATA_WIDTH-1:0] mem_read_data,
  output wire                    mem_read_enable,
  input  logic                   mem_read_ready,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);
  localparam int CW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
  localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam logic [INDEX_WIDTH-1:0] MAX_N = INDEX_WIDTH'(MAX_NODES);

  state_t                 state_q, state_d;
  logic [NUM_LINES-1:0]   valid_q, valid_d, valid_eff;
  logic [INDEX_WIDTH-1:0] tag_q [NUM_LINES];
  logic [INDEX_WIDTH-1:0] tag_d [NUM_LINES];
  logic [VALUE_WIDTH-1:0] lines_q [NUM_LINES][MAX_NODES];
  logic [VALUE_WIDTH-1:0] lines_d [NUM_LINES][MAX_NODES];
  logic [LW-1:0]          rr_q, rr_d, rr_eff, victim_q, victim_d, victim, hit_line;
  logic [INDEX_WIDTH-1:0] from_q, from_d, to_q, to_d, n_eff;
  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic                   oor_q, oor_d, ready_q, ready_d, after_fill_q, after_fill_d, hit;
  logic [15:0]            hit_q, hit_d, miss_q, miss_d;

  logic                   fill_start, fill_busy, fill_req, fill_wr_en, fill_done, fill_complete;
  logic [MADDR_WIDTH-1:0] fill_addr;
  logic [INDEX_WIDTH-1:0] fill_wr_col;
  logic [VALUE_WIDTH-1:0] fill_wr_data;
  logic                   bus_own;

  edge_row_fill #(
    .INDEX_WIDTH(INDEX_WIDTH), .VALUE_WIDTH(VALUE_WIDTH), .MADDR_WIDTH(MADDR_WIDTH),
    .MDATA_WIDTH(MDATA_WIDTH), .WORD_BYTES(WORD_BYTES)
  ) u_fill (
    .clock(clock), .reset(reset), .start(fill_start), .abort(invalidate),
    .base_address(base_address), .row(q.from_node), .n(n_eff),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .busy(fill_busy), .req(fill_req), .addr(fill_addr),
    .wr_en(fill_wr_en), .wr_col(fill_wr_col), .wr_data(fill_wr_data),
    .done(fill_done), .complete(fill_complete)
  );

  // Reset releases the bus combinationally, in the very cycle it is sampled.
  assign bus_own         = fill_busy & ~reset;
  assign mem_read_enable = bus_own ? fill_req : 1'bz;
  assign mem_addr        = bus_own ? fill_addr : {MADDR_WIDTH{1'bz}};

  always_comb begin
    n_eff = (number_of_nodes > MAX_N) ? MAX_N : number_of_nodes;
    // invalidate takes effect this cycle so a concurrent lookup sees no lines
    valid_eff = invalidate ? '0 : valid_q;
    rr_eff    = invalidate ? '0 : rr_q;
    hit       = 1'b0;
    hit_line  = '0;
    victim    = rr_eff;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!valid_eff[i]) victim = LW'(i);
      if (valid_eff[i] && tag_q[i] == q.from_node) begin
        hit      = 1'b1;
        hit_line = LW'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_eff;
    tag_d        = tag_q;
    lines_d      = lines_q;
    rr_d         = rr_eff;
    victim_d     = victim_q;
    from_d       = from_q;
    to_d         = to_q;
    value_d      = value_q;
    oor_d        = oor_q;
    ready_d      = 1'b0;
    after_fill_d = after_fill_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    fill_start   = 1'b0;

    if (fill_wr_en) lines_d[victim_q][fill_wr_col[CW-1:0]] = fill_wr_data;
    if (fill_complete) begin
      valid_d[victim_q] = 1'b1;
      tag_d[victim_q]   = from_q;
    end

    case (state_q)
      IDLE: if (q.query_enable) state_d = LOOKUP;
      LOOKUP: begin
        from_d       = q.from_node;
        to_d         = q.to_node;
        after_fill_d = 1'b0;
        if (q.from_node >= n_eff || q.to_node >= n_eff) begin
          value_d = '0;
          oor_d   = 1'b1;
          state_d = RESPOND;
        end else if (hit) begin
          value_d = lines_q[hit_line][q.to_node[CW-1:0]];
          oor_d   = 1'b0;
          state_d = RESPOND;
          // the lookup that follows a completed fill is not a fresh hit
          if (!after_fill_q && hit_q != 16'hFFFF) hit_d = hit_q + 16'd1;
        end else begin
          victim_d   = victim;
          rr_d       = (rr_eff == LW'(NUM_LINES - 1)) ? '0 : rr_eff + LW'(1);
          fill_start = 1'b1;
          state_d    = FILL_REQ;
          if (miss_q != 16'hFFFF) miss_d = miss_q + 16'd1;
        end
      end
      FILL_REQ: state_d = FILL_WAIT;
      FILL_WAIT: begin
        if (fill_done) begin
          after_fill_d = fill_complete;
          state_d      = LOOKUP;
        end else if (mem_read_ready) begin
          state_d = FILL_REQ;
        end
      end
      RESPOND: begin
        if (!q.query_enable) state_d = IDLE;
        else if (q.from_node != from_q || q.to_node != to_q) state_d = LOOKUP;
        else ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      rr_q         <= '0;
      victim_q     <= '0;
      from_q       <= '0;
      to_q         <= '0;
      value_q      <= '0;
      oor_q        <= 1'b0;
      ready_q      <= 1'b0;
      after_fill_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      rr_q         <= rr_d;
      victim_q     <= victim_d;
      from_q       <= from_d;
      to_q         <= to_d;
      value_q      <= value_d;
      oor_q        <= oor_d;
      ready_q      <= ready_d;
      after_fill_q <= after_fill_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  // Line data and tags are qualified by valid_q, so they need no reset.
  always_ff @(posedge clock) begin
    lines_q <= lines_d;
    tag_q   <= tag_d;
  end

  assign q.ready        = ready_q;
  assign q.edge_value   = value_q;
  assign q.out_of_range = oor_q;
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;
endmodule

// File: tb/tb_edge_row_cache.sv
// tb/tb_edge_row_cache.sv - self-checking bench for edge_row_cache
module tb_edge_row_cache;
  localparam int IW = 8, VW = 16, AW = 16, DW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] base_address = 16'h0034;
  logic [IW-1:0] number_of_nodes = 8'd8;
  logic          invalidate = 1'b0;
  wire  [AW-1:0] mem_addr;
  wire           mem_read_enable;
  logic [DW-1:0] mem_read_data = '0;
  logic          mem_read_ready = 1'b0;
  logic [15:0]   hit_count, miss_count;

  edge_row_cache_if #(.INDEX_WIDTH(IW), .VALUE_WIDTH(VW)) qif ();

  edge_row_cache #(
    .MAX_NODES(16), .INDEX_WIDTH(IW), .VALUE_WIDTH(VW), .MADDR_WIDTH(AW),
    .MDATA_WIDTH(DW), .NUM_LINES(4)
  ) dut (
    .clock(clock), .reset(reset), .base_address(base_address),
    .number_of_nodes(number_of_nodes), .invalidate(invalidate), .q(qif),
    .mem_addr(mem_addr), .mem_read_data(mem_read_data), .mem_read_enable(mem_read_enable),
    .mem_read_ready(mem_read_ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clock = ~clock;

  // BlockRam model: mem[r][c] = 256r + c + 1 at 0x34 + (8r + c)*4, one-cycle read latency.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    int idx;
    idx = (int'(a) - 'h34) / 4;
    return DW'(256 * (idx / 8) + (idx % 8) + 1);
  endfunction

  int            rd_count = 0;
  logic [AW-1:0] rd_addr [0:1023];

  always @(posedge clock) begin
    mem_read_ready <= 1'b0;
    if (mem_read_enable === 1'b1) begin
      mem_read_ready              <= 1'b1;
      mem_read_data               <= mem_word(mem_addr);
      rd_addr[10'(rd_count)]      <= mem_addr;
      rd_count                    <= rd_count + 1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready(output int lat, output int tmo);
    lat = -1;
    tmo = 1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clock);
      #1;
      if (qif.ready === 1'b1) begin
        lat = c;
        tmo = 0;
        break;
      end
    end
  endtask

  task automatic do_query(input int f, input int t, output int lat, output int tmo);
    @(negedge clock);
    qif.query_enable = 1'b1;
    qif.from_node    = IW'(f);
    qif.to_node      = IW'(t);
    wait_ready(lat, tmo);
  endtask

  task automatic release_query();
    @(negedge clock);
    qif.query_enable = 1'b0;
    repeat (2) @(posedge clock);
  endtask

  task automatic reset_dut();
    @(negedge clock);
    qif.query_enable = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    int from; int to; int value; int oor; int lat; int reads; int hits; int misses;
  } vec_t;
  vec_t vecs [7];

  initial begin
    int lat, tmo, r0, h0, m0, seen;
    qif.query_enable = 1'b0;
    qif.from_node    = '0;
    qif.to_node      = '0;

    //        from to value oor lat reads hits misses
    vecs[0] = '{2, 5, 518, 0, 19, 8, 0, 1};
    vecs[1] = '{2, 0, 513, 0,  2, 0, 1, 1};
    vecs[2] = '{2, 7, 520, 0,  2, 0, 2, 1};
    vecs[3] = '{9, 1,   0, 1,  2, 0, 2, 1};
    vecs[4] = '{1, 8,   0, 1,  2, 0, 2, 1};
    vecs[5] = '{0, 7,   8, 0, 19, 8, 2, 2};
    vecs[6] = '{0, 0,   1, 0,  2, 0, 3, 2};

    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", qif.ready, 0);
    check("rst_value", qif.edge_value, 0);
    check("rst_oor", qif.out_of_range, 0);
    check("rst_hits", hit_count, 0);
    check("rst_misses", miss_count, 0);
    check("rst_bus", mem_read_enable === 1'b1, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      r0 = rd_count;
      do_query(vecs[i].from, vecs[i].to, lat, tmo);
      check($sformatf("v%0d_timeout", i), tmo, 0);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_value", i), qif.edge_value, vecs[i].value);
      check($sformatf("v%0d_oor", i), qif.out_of_range, vecs[i].oor);
      check($sformatf("v%0d_hits", i), hit_count, vecs[i].hits);
      check($sformatf("v%0d_misses", i), miss_count, vecs[i].misses);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_hold", i), qif.ready, 1);
      release_query();
      check($sformatf("v%0d_reads", i), rd_count - r0, vecs[i].reads);
    end
    for (int k = 0; k < 8; k++)
      check($sformatf("fill_addr%0d", k), rd_addr[k], 'h34 + (16 + k) * 4);

    // changed to_node while held: ready drops, then the new value arrives
    h0 = hit_count;
    do_query(2, 0, lat, tmo);
    @(negedge clock);
    qif.to_node = 8'd3;
    @(posedge clock);
    #1;
    check("chg_ready_drop", qif.ready, 0);
    wait_ready(lat, tmo);
    check("chg_timeout", tmo, 0);
    check("chg_value", qif.edge_value, 516);
    check("chg_hits", hit_count - h0, 2);
    release_query();

    // invalidate while idle: the next query on a cached row misses
    @(negedge clock);
    invalidate = 1'b1;
    @(negedge clock);
    invalidate = 1'b0;
    r0 = rd_count;
    m0 = miss_count;
    do_query(2, 0, lat, tmo);
    check("inv_idle_value", qif.edge_value, 513);
    check("inv_idle_misses", miss_count - m0, 1);
    release_query();
    check("inv_idle_reads", rd_count - r0, 8);

    // round robin: rows 0..4 fill four lines, row 0 is evicted
    reset_dut();
    for (int r = 0; r < 5; r++) begin
      do_query(r, 0, lat, tmo);
      check($sformatf("rr_row%0d_value", r), qif.edge_value, 256 * r + 1);
      release_query();
    end
    r0 = rd_count;
    do_query(0, 3, lat, tmo);
    check("rr_refill_value", qif.edge_value, 4);
    release_query();
    check("rr_refill_reads", rd_count - r0, 8);
    check("rr_misses", miss_count, 6);
    do_query(4, 1, lat, tmo);
    check("rr_row4_hit_lat", lat, 2);
    check("rr_row4_value", qif.edge_value, 1026);
    release_query();
    check("rr_hits", hit_count, 1);

    // invalidate during fill of row 3, while word 5 is being requested
    reset_dut();
    r0 = rd_count;
    seen = 0;
    @(negedge clock);
    qif.query_enable = 1'b1;
    qif.from_node    = 8'd3;
    qif.to_node      = 8'd2;
    tmo = 1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      invalidate = (seen == 0 && mem_read_enable === 1'b1 && rd_count - r0 == 4);
      if (invalidate) seen = 1;
      if (qif.ready === 1'b1) begin
        tmo = 0;
        break;
      end
    end
    invalidate = 1'b0;
    check("midfill_timeout", tmo, 0);
    check("midfill_pulsed", seen, 1);
    check("midfill_value", qif.edge_value, 771);
    check("midfill_misses", miss_count, 2);
    release_query();
    check("midfill_reads", rd_count - r0, 13);

    // reset during FILL_WAIT
    reset_dut();
    r0 = rd_count;
    seen = 0;
    @(negedge clock);
    qif.query_enable = 1'b1;
    qif.from_node    = 8'd3;
    qif.to_node      = 8'd1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (rd_count - r0 == 3 && mem_read_enable !== 1'b1) begin
        seen = 1;
        break;
      end
    end
    check("rstfill_reached", seen, 1);
    reset = 1'b1;
    qif.query_enable = 1'b0;
    @(posedge clock);
    #1;
    check("rstfill_bus", mem_read_enable === 1'b1, 0);
    check("rstfill_ready", qif.ready, 0);
    @(negedge clock);
    reset = 1'b0;
    check("rstfill_misses", miss_count, 0);
    r0 = rd_count;
    do_query(3, 1, lat, tmo);
    check("rstfill_timeout", tmo, 0);
    check("rstfill_latency", lat, 19);
    check("rstfill_value", qif.edge_value, 770);
    check("rstfill_misses2", miss_count, 1);
    release_query();
    check("rstfill_reads", rd_count - r0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
